// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter serialising core requests onto one single-port RAM.
// state  | meaning
// IDLE   | waiting for a request; winner is registered onto mem_* on the grant edge
// ACCESS | RAM sees stable mem_*; its negedge read lands in mem_dataOut
// ACK    | ack one-hot on grant_id, dataOut valid
module shared_ram_arbiter #(
  parameter int N_CORES    = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int IDX_WIDTH  = $clog2(N_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CORES-1:0]            req,
  input  logic [N_CORES-1:0]            wrEn,
  input  logic [N_CORES*ADDR_WIDTH-1:0] addr,
  input  logic [N_CORES*WIDTH-1:0]      dataIn,
  output logic [N_CORES-1:0]            ack,
  output logic [WIDTH-1:0]              dataOut,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          grant_id,
  output logic                          mem_wrEn,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_dataIn,
  input  logic [WIDTH-1:0]              mem_dataOut
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]            r_state;
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [IDX_WIDTH-1:0]  r_grant_id;
  logic [N_CORES-1:0]    r_ack;
  logic [WIDTH-1:0]      r_data_out;
  logic                  r_busy;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]      r_mem_data_in;

  logic                  w_any;
  logic                  w_hit_hi;
  logic                  w_hit_lo;
  logic [IDX_WIDTH-1:0]  w_win_hi;
  logic [IDX_WIDTH-1:0]  w_win_lo;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [IDX_WIDTH-1:0]  w_next_ptr;
  logic                  w_sel_wr_en;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_data;

  // Two passes: lowest requester at or above ptr, else lowest one below it.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDX_WIDTH'(i) >= r_ptr) begin
          w_hit_hi = 1'b1;
          w_win_hi = IDX_WIDTH'(i);
        end else begin
          w_hit_lo = 1'b1;
          w_win_lo = IDX_WIDTH'(i);
        end
      end
    end
  end

  assign w_any      = w_hit_hi | w_hit_lo;
  assign w_winner   = w_hit_hi ? w_win_hi : w_win_lo;
  assign w_next_ptr = (w_winner == IDX_WIDTH'(N_CORES - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_sel_wr_en = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_winner == IDX_WIDTH'(i)) begin
        w_sel_wr_en = wrEn[i];
        w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data  = dataIn[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_ack         <= '0;
      r_data_out    <= '0;
      r_busy        <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_mem_wr_en   <= w_sel_wr_en;
            r_mem_addr    <= w_sel_addr;
            r_mem_data_in <= w_sel_data;
            r_grant_id    <= w_winner;
            r_ptr         <= w_next_ptr;
            r_busy        <= 1'b1;
            r_state       <= ACCESS;
          end else begin
            r_mem_wr_en   <= 1'b0;
          end
        end
        ACCESS: begin
          // On a write this captures the word being overwritten.
          r_data_out  <= mem_dataOut;
          r_ack       <= {{(N_CORES-1){1'b0}}, 1'b1} << r_grant_id;
          r_mem_wr_en <= 1'b0;
          r_state     <= ACK;
        end
        ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack        = r_ack;
  assign dataOut    = r_data_out;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;
  assign mem_wrEn   = r_mem_wr_en;
  assign mem_addr   = r_mem_addr;
  assign mem_dataIn = r_mem_data_in;

endmodule
